// File: rtl/unary_sched_pkg.sv
// Shared definitions for the unary adder scheduler.
//   state_t          : scheduler FSM states
//   DEF_INPUT_WIDTH  : default unary stream length, shared with the adder
//   count_width()    : bits needed to hold 0..w inclusive
package unary_sched_pkg;

  localparam int unsigned DEF_INPUT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    COLLECT,
    RESPOND
  } state_t;

  function automatic int unsigned count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, reset    : clock, async active-low reset (pointer -> 0)
//   i_req         : request vector
//   i_advance     : accept strobe; moves priority past the current grant
//   o_grant       : one-hot grant (combinational)
//   o_grant_idx   : index of the granted requester
//   o_grant_valid : some requester is granted
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic                i_advance,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_grant_idx,
  output logic                o_grant_valid
);

  // r_ptr holds the first index to search, i.e. last_grant + 1 with wrap.
  logic [ID_WIDTH-1:0] r_ptr;

  always_comb begin
    logic [ID_WIDTH-1:0] v_idx;
    v_idx         = '0;
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      v_idx = ID_WIDTH'((32'(r_ptr) + off) % NUM_REQ);
      if (!o_grant_valid && i_req[v_idx]) begin
        o_grant_valid  = 1'b1;
        o_grant[v_idx] = 1'b1;
        o_grant_idx    = v_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_advance && o_grant_valid) begin
      r_ptr <= (o_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : o_grant_idx + ID_WIDTH'(1);
    end
  end

endmodule

// File: rtl/unary_add_scheduler.sv
// Time-shares one external unary bitstream adder among NUM_REQ requesters.
//   clk, reset           : clock, async active-low reset
//   req_valid/ready/a/b  : per-requester binary operand pairs, one-hot accept pulse
//   rsp_*                : result (id, '1' count, valid-bit count, short flag)
//   add_rst_n            : adder reset, low for one CLEAR cycle per job and during reset
//   add_ready/add_a/add_b: thermometer-coded unary streams to the adder
//   add_valid/add_y      : adder output sample
module unary_add_scheduler
  import unary_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int unsigned COUNT_WIDTH = count_width(INPUT_WIDTH),
  parameter int unsigned ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [COUNT_WIDTH-1:0]         rsp_sum,
  output logic [COUNT_WIDTH-1:0]         rsp_len,
  output logic                           rsp_short,
  output logic                           add_rst_n,
  output logic [1:0]                     add_ready,
  output logic                           add_a,
  output logic                           add_b,
  input  logic                           add_valid,
  input  logic                           add_y
);

  localparam logic [COUNT_WIDTH-1:0] W_C    = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] K_LAST = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);

  state_t                  r_state, w_next;
  logic [COUNT_WIDTH-1:0]  r_op_a, r_op_b, r_k, r_sum, r_len;
  logic [ID_WIDTH-1:0]     r_id;
  logic                    r_sample_en;

  logic [NUM_REQ-1:0]      w_grant;
  logic [ID_WIDTH-1:0]     w_grant_idx;
  logic                    w_grant_valid, w_accept;
  logic [COUNT_WIDTH-1:0]  w_a_arr [NUM_REQ];
  logic [COUNT_WIDTH-1:0]  w_b_arr [NUM_REQ];
  logic [COUNT_WIDTH-1:0]  w_sel_a, w_sel_b;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a_arr[g] = req_a[g*COUNT_WIDTH +: COUNT_WIDTH];
    assign w_b_arr[g] = req_b[g*COUNT_WIDTH +: COUNT_WIDTH];
  end

  always_comb begin
    w_sel_a = (w_a_arr[w_grant_idx] > W_C) ? W_C : w_a_arr[w_grant_idx];
    w_sel_b = (w_b_arr[w_grant_idx] > W_C) ? W_C : w_b_arr[w_grant_idx];
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .clk           (clk),
    .reset         (reset),
    .i_req         (req_valid),
    .i_advance     (w_accept),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    req_ready = '0;
    add_ready = 2'b00;
    add_a     = 1'b0;
    add_b     = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_sum   = '0;
    rsp_len   = '0;
    rsp_short = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Reset keeps the FSM in IDLE, so the accept pulse must be gated by it.
        if (w_grant_valid && reset) begin
          w_accept  = 1'b1;
          req_ready = w_grant;
          w_next    = CLEAR;
        end
      end
      CLEAR: w_next = STREAM;
      STREAM: begin
        add_ready = 2'b11;
        add_a     = (r_k < r_op_a);
        add_b     = (r_k < r_op_b);
        if (r_k == K_LAST) w_next = COLLECT;
      end
      COLLECT: w_next = RESPOND;
      RESPOND: begin
        rsp_valid = 1'b1;
        rsp_id    = r_id;
        rsp_sum   = r_sum;
        rsp_len   = r_len;
        rsp_short = (r_len < W_C);
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign add_rst_n = reset && (r_state != CLEAR);

  // The adder output is registered, so a sample is valid one cycle after ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_id        <= '0;
      r_k         <= '0;
      r_sum       <= '0;
      r_len       <= '0;
      r_sample_en <= 1'b0;
    end else begin
      r_sample_en <= (r_state == STREAM);
      if (w_accept) begin
        r_op_a <= w_sel_a;
        r_op_b <= w_sel_b;
        r_id   <= w_grant_idx;
      end
      if (r_state == CLEAR) begin
        r_k   <= '0;
        r_sum <= '0;
        r_len <= '0;
      end else begin
        if (r_state == STREAM) r_k <= r_k + ONE;
        if (r_sample_en && add_valid) begin
          if (r_len != W_C)          r_len <= r_len + ONE;
          if (add_y && r_sum != W_C) r_sum <= r_sum + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_unary_add_scheduler.sv
// Directed bench for unary_add_scheduler with a small mean-of-two adder model:
// the model alternates between the a stream (even k) and the b stream (odd k),
// registers its output, and holds a stale valid while ready is low.
module tb_unary_add_scheduler;

  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int CW  = 6;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*CW-1:0]  req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [CW-1:0]     rsp_sum, rsp_len;
  logic              rsp_short;
  logic              add_rst_n;
  logic [1:0]        add_ready;
  logic              add_a, add_b;
  logic              add_valid, add_y;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  unary_add_scheduler #(
    .NUM_REQ     (NR),
    .INPUT_WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_len   (rsp_len),
    .rsp_short (rsp_short),
    .add_rst_n (add_rst_n),
    .add_ready (add_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_valid (add_valid),
    .add_y     (add_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model
  logic m_sel;
  always @(posedge clk or negedge add_rst_n) begin
    if (!add_rst_n) begin
      add_valid <= 1'b0;
      add_y     <= 1'b0;
      m_sel     <= 1'b0;
    end else if (add_ready == 2'b11) begin
      add_valid <= 1'b1;
      add_y     <= m_sel ? add_b : add_a;
      m_sel     <= ~m_sel;
    end
  end

  // Per-job stream statistics, restarted on every accept pulse.
  int n_rdy, n_a, n_b, n_rstl, n_order;
  logic a_fell, b_fell;
  always @(negedge clk) begin
    if (req_ready != '0) begin
      n_rdy = 0; n_a = 0; n_b = 0; n_rstl = 0; n_order = 0;
      a_fell = 1'b0; b_fell = 1'b0;
    end else begin
      if (!add_rst_n) n_rstl++;
      if (add_ready == 2'b11) begin
        n_rdy++;
        if (add_a) begin n_a++; if (a_fell) n_order++; end else a_fell = 1'b1;
        if (add_b) begin n_b++; if (b_fell) n_order++; end else b_fell = 1'b1;
      end else if (add_a || add_b) begin
        n_order++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input int a, input int b);
    req_a[idx*CW +: CW] = CW'(a);
    req_b[idx*CW +: CW] = CW'(b);
  endtask

  // Waits (bounded) for an accept pulse; returns the observed pulse vector.
  task automatic wait_grant(input string tag, output logic [NR-1:0] g, output int t);
    g = '0;
    t = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready;
        t = cyc;
        break;
      end
    end
    if (g == '0) check({tag, "_grant_timeout"}, 0, 1);
  endtask

  task automatic wait_rsp(input string tag, output int t);
    logic seen;
    seen = 1'b0;
    t = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!seen) check({tag, "_rsp_timeout"}, 0, 1);
  endtask

  // Called in a drive slot; returns at the first negedge showing rsp_valid.
  task automatic do_job(input string tag, input int idx, input int a, input int b,
                        input int exp_sum, input int exp_na, input int exp_nb);
    logic [NR-1:0] g;
    int t0, t1;
    set_ops(idx, a, b);
    req_valid[idx] = 1'b1;
    wait_grant(tag, g, t0);
    check({tag, "_grant"}, 32'(g), 32'(1 << idx));
    drive_slot();
    req_valid[idx] = 1'b0;
    wait_rsp(tag, t1);
    check({tag, "_latency"}, t1 - t0, W + 3);
    check({tag, "_id"},    32'(rsp_id),    idx);
    check({tag, "_sum"},   32'(rsp_sum),   exp_sum);
    check({tag, "_len"},   32'(rsp_len),   W);
    check({tag, "_short"}, 32'(rsp_short), 0);
    check({tag, "_nrdy"},  n_rdy,  W);
    check({tag, "_na"},    n_a,    exp_na);
    check({tag, "_nb"},    n_b,    exp_nb);
    check({tag, "_rstl"},  n_rstl, 1);
    check({tag, "_therm"}, n_order, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] g;
    logic [NR-1:0] exp_g;
    int t0, t1, err;

    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    set_ops(0, 10, 20);
    req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    // Reset state: everything low, accept suppressed even with a request pending.
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_add_rst_n", 32'(add_rst_n), 0);
    check("rst_add_ready", 32'(add_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_short", 32'(rsp_short), 0);
    drive_slot();
    req_valid = '0;
    reset = 1'b1;
    drive_slot();

    // Basic operand patterns
    do_job("t1_a10_b20", 0, 10, 20, 15, 10, 20);
    drive_slot();
    do_job("t2_zero", 1, 0, 0, 0, 0, 0);
    drive_slot();
    do_job("t2_full", 2, 32, 32, 32, 32, 32);
    drive_slot();
    do_job("t6_clamp", 0, 40, 8, 20, 32, 8);
    drive_slot();
    do_job("t6_ref", 3, 32, 8, 20, 32, 8);
    drive_slot();

    // Round-robin order with all requesters held valid
    apply_reset();
    for (int i = 0; i < NR; i++) set_ops(i, 0, 0);
    req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_grant("t3", g, t0);
      exp_g = NR'(1 << (j % NR));
      check($sformatf("t3_grant%0d", j), 32'(g), 32'(exp_g));
      @(negedge clk);
      check($sformatf("t3_pulse%0d", j), 32'(req_ready), 0);
    end
    drive_slot();
    req_valid = '0;
    wait_rsp("t3_last", t1);
    check("t3_last_id", 32'(rsp_id), 0);
    drive_slot();

    // Response back-pressure
    rsp_ready = 1'b0;
    do_job("t4", 1, 5, 7, 6, 5, 7);
    drive_slot();
    set_ops(2, 3, 3);
    req_valid[2] = 1'b1;
    err = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_sum != 6 || rsp_id != 1 || rsp_len != W || req_ready != '0) err++;
    end
    check("t4_hold_stable", err, 0);
    drive_slot();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", 32'(rsp_valid), 1);
    check("t4_release_noacc", 32'(req_ready), 0);
    @(negedge clk);
    check("t4_next_grant", 32'(req_ready), 32'(4'b0100));
    drive_slot();
    req_valid[2] = 1'b0;
    wait_rsp("t4b", t1);
    check("t4b_id", 32'(rsp_id), 2);
    check("t4b_sum", 32'(rsp_sum), 3);
    drive_slot();

    // Reset in the middle of STREAM (k=12); request stays pending
    set_ops(3, 32, 32);
    req_valid[3] = 1'b1;
    wait_grant("t5", g, t0);
    check("t5_grant", 32'(g), 32'(4'b1000));
    err = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (n_rdy == 13) begin err = 0; break; end
    end
    check("t5_reach_k12", err, 0);
    #1;
    reset = 1'b0;
    #1;
    check("t5_add_rst_n", 32'(add_rst_n), 0);
    check("t5_add_ready", 32'(add_ready), 0);
    check("t5_add_ab", 32'({add_a, add_b}), 0);
    check("t5_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_grant("t5_re", g, t0);
    check("t5_regrant", 32'(g), 32'(4'b1000));
    check("t5_no_stale_rsp", 32'(rsp_valid), 0);
    drive_slot();
    req_valid[3] = 1'b0;
    wait_rsp("t5_re", t1);
    check("t5_latency", t1 - t0, W + 3);
    check("t5_sum", 32'(rsp_sum), 32);
    check("t5_len", 32'(rsp_len), 32);
    check("t5_short", 32'(rsp_short), 0);
    drive_slot();
    @(negedge clk);
    check("t5_idle_after", 32'(rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
